mem_port_arbiter: RTL and testbench

//  Shares one unified single-ported memory between the pipeline's fetch port (IF) and data port (DM).

---
 rtl/mem_arb_pkg.sv | 10 +
 rtl/mem_arb_wdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter (fetch vs. data port).
package mem_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;

  // Fetches are always full-word reads; this is the existing memsize word code.
  localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_arb_wdog.sv
// Response watchdog: counts cycles while run is high, clears on clr, flags expire at TIMEOUT.
module mem_arb_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run && !expire) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // TIMEOUT of zero disables the watchdog entirely.
  assign expire = (TIMEOUT != 0) && run && (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (IF) and data (DM) ports onto one single-ported memory, one access in flight.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise DM always beats IF.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_kill,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_busy,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [2:0]      dm_size,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic            dm_gnt,
  output logic            dm_rvalid,
  output logic [XLEN-1:0] dm_rdata,
  output logic            dm_busy,
  output logic            mem_req,
  output logic            mem_we,
  output logic [2:0]      mem_size,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            err
);

  arb_state_t      r_state, w_state_next;
  arb_owner_t      r_owner;
  logic            r_killed, r_err;
  logic            r_we;
  logic [2:0]      r_size;
  logic [XLEN-1:0] r_addr, r_wdata;

  logic w_if_cand, w_dm_cand, w_prefer_if, w_if_win, w_dm_win;
  logic w_busy_state, w_killed, w_expire, w_done, w_abort, w_fin, w_clr;

`ifdef MEM_ARB_RR_EN
  arb_owner_t r_last;

  // Starts at IF so that the first tie after reset goes to DM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= OWN_IF;
    end else if (w_if_win) begin
      r_last <= OWN_IF;
    end else if (w_dm_win) begin
      r_last <= OWN_DM;
    end
  end

  assign w_prefer_if = (r_last == OWN_DM);
`else
  assign w_prefer_if = 1'b0;
`endif

  // Outputs are gated by reset so nothing escapes while it is asserted.
  assign w_if_cand = reset && (r_state == ARB_IDLE) && if_req && !if_kill;
  assign w_dm_cand = reset && (r_state == ARB_IDLE) && dm_req;
  assign w_if_win  = w_if_cand && (!w_dm_cand || w_prefer_if);
  assign w_dm_win  = w_dm_cand && (!w_if_cand || !w_prefer_if);

  assign w_busy_state = (r_state != ARB_IDLE);
  assign w_killed     = r_killed || (if_kill && w_busy_state && (r_owner == OWN_IF));
  assign w_done       = (r_state == ARB_RESP) && mem_rvalid;
  assign w_abort      = w_expire && !w_done;
  assign w_fin        = w_done || w_abort;
  assign w_clr        = (w_state_next != r_state);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_if_win || w_dm_win) w_state_next = ARB_REQ;
      ARB_REQ: begin
        if (w_expire)     w_state_next = ARB_IDLE;
        else if (mem_gnt) w_state_next = ARB_RESP;
      end
      ARB_RESP: if (w_fin) w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ARB_IDLE;
      r_owner  <= OWN_IF;
      r_killed <= 1'b0;
      r_err    <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_dm_win) begin
        r_owner <= OWN_DM;
        r_we    <= dm_we;
        r_size  <= dm_size;
        r_addr  <= dm_addr;
        r_wdata <= dm_wdata;
      end else if (w_if_win) begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_size  <= FETCH_SIZE;
        r_addr  <= if_addr;
        r_wdata <= '0;
      end
      if (w_state_next == ARB_IDLE) begin
        r_killed <= 1'b0;
      end else if (w_killed) begin
        r_killed <= 1'b1;
      end
      if (w_abort) r_err <= 1'b1;
    end
  end

  mem_arb_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (w_clr),
    .run    (w_busy_state),
    .expire (w_expire)
  );

  assign if_gnt    = w_if_win;
  assign dm_gnt    = w_dm_win;
  assign if_rvalid = reset && w_fin && (r_owner == OWN_IF) && !w_killed;
  assign dm_rvalid = reset && w_fin && (r_owner == OWN_DM);
  // Aborted transactions return zero data.
  assign if_rdata  = (if_rvalid && w_done) ? mem_rdata : '0;
  assign dm_rdata  = (dm_rvalid && w_done) ? mem_rdata : '0;
  assign if_busy   = reset && if_req && !if_rvalid;
  assign dm_busy   = reset && dm_req && !dm_rvalid;

  assign mem_req   = reset && (r_state == ARB_REQ) && !w_expire;
  assign mem_we    = r_we;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard queues per port plus a simple memory model.
module tb_mem_port_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TO   = 8;

  logic            clk, reset;
  logic            if_req, if_kill, if_gnt, if_rvalid, if_busy;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            dm_req, dm_we, dm_gnt, dm_rvalid, dm_busy;
  logic [2:0]      dm_size, mem_size;
  logic [XLEN-1:0] dm_addr, dm_wdata, dm_rdata;
  logic            mem_req, mem_we, mem_gnt, mem_rvalid, err;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {bit chk; logic [31:0] d;} exp_t;
  logic [31:0] if_q[$];
  exp_t        dm_q[$];
  logic [31:0] mem_arr[logic [31:0]];
  bit          gnt_en, rv_en, acc_seen, outstanding, rv_done;
  logic [31:0] rd_data;
  logic [31:0] mon_e;
  exp_t        mon_x;

  mem_port_arbiter #(
    .XLEN(XLEN),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_busy(if_busy),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dm_busy(dm_busy), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {a[15:0], 16'h5A5A};
  endfunction

  // Memory model: grant same cycle as mem_req, answer in the cycle after acceptance.
  always begin
    @(posedge clk);
    #1;
    if (rv_done) outstanding = 1'b0;
    if (acc_seen) outstanding = 1'b1;
    mem_gnt    = gnt_en & mem_req;
    mem_rvalid = rv_en & outstanding;
    mem_rdata  = mem_rvalid ? rd_data : 32'h0;
    rv_done    = mem_rvalid;
  end

  always @(negedge clk) begin
    acc_seen = mem_req & mem_gnt;
    if (acc_seen) begin
      if (mem_we) begin
        mem_arr[mem_addr] = mem_wdata;
        rd_data = 32'h0;
      end else begin
        rd_data = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : exp_word(mem_addr);
      end
    end
  end

  // Scoreboard: every response pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    if (if_rvalid) begin
      n_checks++;
      if (if_q.size() == 0) begin
        n_errors++;
        $display("FAIL if_rvalid_unexpected got rdata=%h want no pulse", if_rdata);
      end else begin
        mon_e = if_q.pop_front();
        if (if_rdata !== mon_e) begin
          n_errors++;
          $display("FAIL if_rdata got %h want %h", if_rdata, mon_e);
        end
      end
    end
    if (dm_rvalid) begin
      n_checks++;
      if (dm_q.size() == 0) begin
        n_errors++;
        $display("FAIL dm_rvalid_unexpected got rdata=%h want no pulse", dm_rdata);
      end else begin
        mon_x = dm_q.pop_front();
        if (mon_x.chk && dm_rdata !== mon_x.d) begin
          n_errors++;
          $display("FAIL dm_rdata got %h want %h", dm_rdata, mon_x.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_q.size() == 0 && dm_q.size() == 0) break;
    end
    tick();
  endtask

  task automatic test_reset();
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h44; dm_addr = 32'h88;
    #3;
    n_checks++;
    if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_gnt got if=%b dm=%b mem_req=%b want 0/0/0", if_gnt, dm_gnt, mem_req);
    end
    n_checks++;
    if (mem_addr !== 32'h0 || mem_we !== 1'b0 || err !== 1'b0 || if_rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_regs got addr=%h we=%b err=%b rv=%b want 0", mem_addr, mem_we, err,
               if_rvalid);
    end
    tick();
    n_checks++;
    if (if_gnt !== 1'b0 || dm_gnt !== 1'b0 || mem_req !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold got if=%b dm=%b mem_req=%b want 0/0/0", if_gnt, dm_gnt, mem_req);
    end
    if_req = 1'b0; dm_req = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    mem_arr[32'h100] = 32'h0050_0093;
    if_q.push_back(32'h0050_0093);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1 || dm_gnt !== 1'b0 || if_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL fetch_gnt_c0 got gnt=%b dm=%b busy=%b want 1/0/1", if_gnt, dm_gnt, if_busy);
    end
    tick(); if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL fetch_mem_c1 got req=%b addr=%h we=%b want 1/100/0", mem_req, mem_addr, mem_we);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (if_rvalid !== 1'b1) begin
      n_errors++;
      $display("FAIL fetch_rvalid_c2 got %b want 1", if_rvalid);
    end
    wait_drain();
    n_checks++;
    if (if_q.size() != 0) begin
      n_errors++;
      $display("FAIL fetch_drain got %0d pending want 0", if_q.size());
    end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 3'b101; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    dm_q.push_back('{1'b0, 32'h0});
    if_q.push_back(exp_word(32'h104));
    @(negedge clk);
    n_checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || dm_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_c0 got dm=%b if=%b dm_busy=%b want 1/0/1", dm_gnt, if_gnt, dm_busy);
    end
    tick(); dm_req = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2000 ||
        mem_size !== 3'b101 || if_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_store_c1 got we=%b wd=%h a=%h sz=%b ifg=%b want 1/deadbeef/2000/101/0",
               mem_we, mem_wdata, mem_addr, mem_size, if_gnt);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (dm_rvalid !== 1'b1 || if_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL prio_c2 got dm_rvalid=%b if_gnt=%b want 1/0", dm_rvalid, if_gnt);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL prio_if_c3 got if_gnt=%b want 1", if_gnt);
    end
    tick(); if_req = 1'b0;
    wait_drain();
    dm_q.push_back('{1'b1, 32'hDEAD_BEEF});
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
    @(negedge clk);
    n_checks++;
    if (dm_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL load_gnt got %b want 1", dm_gnt);
    end
    tick(); dm_req = 1'b0;
    wait_drain();
    n_checks++;
    if (if_q.size() + dm_q.size() != 0) begin
      n_errors++;
      $display("FAIL prio_drain got %0d pending want 0", if_q.size() + dm_q.size());
    end
  endtask

  task automatic test_kill();
    if_req = 1'b1; if_kill = 1'b1; if_addr = 32'h108;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b0 || if_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL kill_idle got gnt=%b busy=%b want 0/1", if_gnt, if_busy);
    end
    tick(); if_kill = 1'b0; rv_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL kill_gnt got %b want 1", if_gnt);
    end
    tick(); if_req = 1'b0;
    tick(); if_kill = 1'b1; rv_en = 1'b1;
    tick(); if_kill = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL kill_suppress got if_rvalid=%b dm_rvalid=%b want 0/0", if_rvalid, dm_rvalid);
    end
    tick();
    if_q.push_back(exp_word(32'h10C));
    if_req = 1'b1; if_addr = 32'h10C;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL kill_next_gnt got %b want 1", if_gnt);
    end
    tick(); if_req = 1'b0;
    wait_drain();
    n_checks++;
    if (if_q.size() != 0) begin
      n_errors++;
      $display("FAIL kill_drain got %0d pending want 0", if_q.size());
    end
  endtask

  task automatic test_timeout();
    int cyc;
    cyc = 0;
    gnt_en = 1'b0;
    if_q.push_back(32'h0);
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL wdog_gnt got %b want 1", if_gnt);
    end
    tick(); if_req = 1'b0;
    for (int k = 1; k <= 4 * TO && cyc == 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_checks++;
        if (err !== 1'b0) begin
          n_errors++;
          $display("FAIL wdog_err_early got %b want 0", err);
        end
      end
      if (k == TO) begin
        n_checks++;
        if (mem_req !== 1'b1) begin
          n_errors++;
          $display("FAIL wdog_req_held got %b want 1", mem_req);
        end
      end
      if (if_rvalid === 1'b1) begin
        cyc = k;
        n_checks++;
        if (mem_req !== 1'b0) begin
          n_errors++;
          $display("FAIL wdog_req_drop got %b want 0", mem_req);
        end
      end
    end
    n_checks++;
    if (cyc != TO + 1) begin
      n_errors++;
      $display("FAIL wdog_latency got %0d want %0d", cyc, TO + 1);
    end
    tick(); gnt_en = 1'b1;
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++;
      $display("FAIL wdog_err got %b want 1", err);
    end
    if_q.push_back(exp_word(32'h120));
    if_req = 1'b1; if_addr = 32'h120;
    tick(); if_req = 1'b0;
    wait_drain();
    n_checks++;
    if (err !== 1'b1 || if_q.size() != 0) begin
      n_errors++;
      $display("FAIL wdog_sticky got err=%b pending=%0d want 1/0", err, if_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rv_en = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    @(negedge clk);
    n_checks++;
    if (dm_gnt !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_gnt got %b want 1", dm_gnt);
    end
    tick(); dm_req = 1'b0;
    tick();
    reset = 1'b0; dm_req = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || dm_gnt !== 1'b0 || dm_rvalid !== 1'b0 || dm_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_out got req=%b gnt=%b rv=%b busy=%b want 0", mem_req, dm_gnt,
               dm_rvalid, dm_busy);
    end
    n_checks++;
    if (err !== 1'b0 || mem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_mid_regs got err=%b addr=%h want 0/0", err, mem_addr);
    end
    tick(); dm_req = 1'b0; reset = 1'b1; rv_en = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dm_gnt !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_stale got dm_rv=%b if_rv=%b gnt=%b want 0/0/0", dm_rvalid, if_rvalid,
               dm_gnt);
    end
    tick();
  endtask

  task automatic test_arbitration();
    int got;
    bit want_dm;
    got = 0;
    if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (if_gnt === 1'b1 && dm_gnt === 1'b1) begin
        n_checks++;
        n_errors++;
        $display("FAIL arb_double got if=1 dm=1 want one grant");
        got++;
      end else if (if_gnt === 1'b1 || dm_gnt === 1'b1) begin
`ifdef MEM_ARB_RR_EN
        want_dm = (got % 2 == 0);
`else
        want_dm = 1'b1;
`endif
        n_checks++;
        if (dm_gnt !== want_dm) begin
          n_errors++;
          $display("FAIL arb_order_%0d got dm_gnt=%b want %b", got, dm_gnt, want_dm);
        end
        if (dm_gnt === 1'b1) dm_q.push_back('{1'b1, exp_word(32'h500)});
        else if_q.push_back(exp_word(32'h400));
        got++;
      end
    end
    tick(); if_req = 1'b0; dm_req = 1'b0;
    n_checks++;
    if (got != 4) begin
      n_errors++;
      $display("FAIL arb_count got %0d grants want 4", got);
    end
    wait_drain();
    n_checks++;
    if (if_q.size() + dm_q.size() != 0) begin
      n_errors++;
      $display("FAIL arb_drain got %0d pending want 0", if_q.size() + dm_q.size());
    end
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_kill = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_size = 3'b010; dm_addr = '0; dm_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rd_data = '0;
    gnt_en = 1'b1; rv_en = 1'b1;
    test_reset();
    test_fetch();
    test_priority();
    test_kill();
    test_timeout();
    test_reset_mid();
    test_arbitration();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
